// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} fetch_state_e;

    // Enumeration order doubles as redirect priority (higher value wins).
    typedef enum logic [2:0] {NONE, PRED, JAL, MISDIR, MISPRED} redir_src_e;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_steer_ctrl_if.sv
// Redirect/prediction inputs and fetch-control outputs of the fetch steering controller.
interface fetch_steer_ctrl_if #(
    parameter int WIDTH      = 31,
    parameter int EPOCH_BITS = 2
);
    logic             mispredict;
    logic [WIDTH:0]   mispredictTarget;
    logic             misdirect;
    logic [WIDTH:0]   misdirectTarget;
    logic             isJAL;
    logic [WIDTH:0]   jalTarget;
    logic             predictorHit;
    logic [WIDTH:0]   predictedPC;
    logic             freeze;
    logic [WIDTH:0]   fetchPC;
    logic             fetchValid;
    logic             pcEn;
    logic             flushF;
    logic             flushD;
    logic             redirect;
    logic [EPOCH_BITS-1:0] epoch;

    // master: the controller; slave: the surrounding pipeline/predictor.
    modport master (
        input  mispredict, mispredictTarget, misdirect, misdirectTarget,
               isJAL, jalTarget, predictorHit, predictedPC, freeze,
        output fetchPC, fetchValid, pcEn, flushF, flushD, redirect, epoch
    );

    modport slave (
        output mispredict, mispredictTarget, misdirect, misdirectTarget,
               isJAL, jalTarget, predictorHit, predictedPC, freeze,
        input  fetchPC, fetchValid, pcEn, flushF, flushD, redirect, epoch
    );
endinterface

// File: rtl/fetch_steer_ctrl_pc_next_mux.sv
// Priority select of the next fetch PC and the source that produced it.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int WIDTH = 31
) (
    input  logic           mispredict,
    input  logic [WIDTH:0] mispredict_target,
    input  logic           misdirect,
    input  logic [WIDTH:0] misdirect_target,
    input  logic           is_jal,
    input  logic [WIDTH:0] jal_target,
    input  logic           predictor_hit,
    input  logic [WIDTH:0] predicted_pc,
    input  logic [WIDTH:0] fetch_pc,
    output logic [WIDTH:0] next_pc,
    output redir_src_e     next_src
);

    always_comb begin
        next_pc  = fetch_pc + (WIDTH+1)'(PC_INCR);
        next_src = NONE;
        if (mispredict) begin
            next_pc  = mispredict_target;
            next_src = MISPRED;
        end else if (misdirect) begin
            next_pc  = misdirect_target;
            next_src = MISDIR;
        end else if (is_jal) begin
            next_pc  = jal_target;
            next_src = JAL;
        end else if (predictor_hit) begin
            next_pc  = predicted_pc;
            next_src = PRED;
        end
    end

endmodule

// File: rtl/fetch_steer_ctrl.sv
// Fetch sequencing controller: owns the fetch PC, arbitrates redirects,
// handles backend freeze with a deferred redirect and squashes wrong-path fetches.
module fetch_steer_ctrl
    import fetch_pkg::*;
#(
    parameter int              WIDTH        = 31,
    parameter logic [WIDTH:0]  RESET_VECTOR = '0,
    parameter int              EPOCH_BITS   = 2,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetN,
    fetch_steer_ctrl_if.master bus
);

    localparam logic [1:0] S_BOOT  = BOOT;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_STALL = STALL;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES);
    localparam logic [EPOCH_BITS-1:0] EPOCH_ONE = EPOCH_BITS'(1);

    logic [1:0]            state_q, state_d;
    logic [WIDTH:0]        pc_q, pc_d;
    logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    redir_src_e            pend_src_q, pend_src_d;
    logic [WIDTH:0]        pend_tgt_q, pend_tgt_d;
    logic                  redirect_q, redirect_d;

    logic           flush_f, flush_d, fetch_valid, pc_en, take;
    logic [WIDTH:0] take_tgt, mux_pc;
    redir_src_e     mux_src;

    // A prediction only steers the PC when the current fetch is actually accepted.
    pc_next_mux #(.WIDTH(WIDTH)) u_mux (
        .mispredict        (bus.mispredict),
        .mispredict_target (bus.mispredictTarget),
        .misdirect         (bus.misdirect),
        .misdirect_target  (bus.misdirectTarget),
        .is_jal            (bus.isJAL),
        .jal_target        (bus.jalTarget),
        .predictor_hit     (bus.predictorHit && (state_q == S_RUN) && !bus.freeze),
        .predicted_pc      (bus.predictedPC),
        .fetch_pc          (pc_q),
        .next_pc           (mux_pc),
        .next_src          (mux_src)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_src_d  = pend_src_q;
        pend_tgt_d  = pend_tgt_q;
        redirect_d  = 1'b0;
        flush_f     = 1'b0;
        flush_d     = 1'b0;
        fetch_valid = 1'b0;
        pc_en       = 1'b0;
        take        = 1'b0;
        take_tgt    = mux_pc;

        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                fetch_valid = 1'b1;
                pc_en       = !bus.freeze;
                if (mux_src >= JAL) begin
                    take = 1'b1;
                end else if (bus.freeze) begin
                    state_d = S_STALL;
                end else begin
                    pc_d       = mux_pc;
                    redirect_d = (mux_src == PRED);
                end
            end
            S_STALL: begin
                fetch_valid = 1'b1;
                if (mux_src == MISPRED) begin
                    take = 1'b1;
                end else begin
                    // Newer or higher-priority decode redirect replaces the held one.
                    if (mux_src != NONE && (!pend_q || mux_src >= pend_src_q)) begin
                        pend_d     = 1'b1;
                        pend_src_d = mux_src;
                        pend_tgt_d = mux_pc;
                    end
                    if (!bus.freeze) begin
                        if (pend_d) begin
                            take     = 1'b1;
                            take_tgt = pend_tgt_d;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_FLUSH: begin
                pc_en = 1'b1;
                if (mux_src == MISPRED) begin
                    take = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = bus.freeze ? S_STALL : S_RUN;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (take) begin
            pc_d       = take_tgt;
            epoch_d    = epoch_q + EPOCH_ONE;
            cnt_d      = CNT_INIT;
            state_d    = S_FLUSH;
            pend_d     = 1'b0;
            redirect_d = 1'b1;
            flush_f    = 1'b1;
            flush_d    = (mux_src == MISPRED);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            epoch_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_src_q <= NONE;
            pend_tgt_q <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.fetchPC    = pc_q;
    assign bus.fetchValid = fetch_valid;
    assign bus.pcEn       = pc_en;
    assign bus.flushF     = flush_f;
    assign bus.flushD     = flush_d;
    assign bus.redirect   = redirect_q;
    assign bus.epoch      = epoch_q;

endmodule
